// File: rtl/div_pkg.sv
// Shared types for the divider dispatcher: default width, FSM states, result record.
package div_pkg;

  localparam int unsigned DIV_W = 10;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE
  } div_state_e;

  typedef struct packed {
    logic [DIV_W-1:0] q;
    logic             ov;
    logic             dvz;
    logic             tmo;
  } div_res_t;

endpackage

// File: rtl/div_req_fifo.sv
// Request FIFO holding {a, b} operand pairs; a push into a full FIFO is refused even if a pop coincides.
module div_req_fifo
  import div_pkg::*;
#(
  parameter int unsigned W     = DIV_W,
  parameter int unsigned DEPTH = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         push_i,
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         pop_i,
  output logic [W-1:0] a_o,
  output logic [W-1:0] b_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [2*W-1:0] mem_q [DEPTH];
  logic [AW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [AW:0]    count_q;
  logic           push_ok, pop_ok;

  assign full_o     = (count_q == FULL_CNT);
  assign empty_o    = (count_q == '0);
  assign push_ok    = push_i & ~full_o;
  assign pop_ok     = pop_i & ~empty_o;
  assign {a_o, b_o} = mem_q[rd_ptr_q];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      // Pointers are log2(DEPTH) wide, so increments wrap modulo DEPTH.
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
      unique case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= {a_i, b_i};
  end

endmodule

// File: rtl/div_dispatch.sv
// Queues divide requests and issues them one at a time to an external divider with timeout.
// Optional: DIV_DISPATCH_DVZ_BYPASS_EN completes divide-by-zero requests without the divider.
module div_dispatch
  import div_pkg::*;
#(
  parameter int unsigned W       = DIV_W,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = 48
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [W-1:0] req_a,
  input  logic [W-1:0] req_b,
  output logic         div_start,
  output logic [W-1:0] div_a,
  output logic [W-1:0] div_b,
  input  logic         div_busy,
  input  logic         div_valid,
  input  logic         div_ov,
  input  logic         div_dvz,
  input  logic [W-1:0] div_q,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [W-1:0] res_q,
  output logic         res_ov,
  output logic         res_dvz,
  output logic         res_tmo
);

  localparam int unsigned CW = $clog2(TIMEOUT) + 1;

  div_state_e    state_q, state_d;
  logic [W-1:0]  op_a_q, op_a_d, op_b_q, op_b_d;
  logic [W-1:0]  res_q_q, res_q_d;
  logic          res_ov_q, res_ov_d, res_dvz_q, res_dvz_d, res_tmo_q, res_tmo_d;
  logic [CW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic          fifo_pop, fifo_full, fifo_empty;
  logic [W-1:0]  fifo_a, fifo_b;

  div_req_fifo #(.W(W), .DEPTH(DEPTH)) u_fifo (
    .clk_i   (clk),
    .rst_i   (rst),
    .push_i  (req_valid),
    .a_i     (req_a),
    .b_i     (req_b),
    .pop_i   (fifo_pop),
    .a_o     (fifo_a),
    .b_o     (fifo_b),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign req_ready = ~fifo_full;
  assign div_start = (state_q == ISSUE);
  assign div_a     = op_a_q;
  assign div_b     = op_b_q;
  assign res_valid = (state_q == DONE);
  assign res_q     = res_q_q;
  assign res_ov    = res_ov_q;
  assign res_dvz   = res_dvz_q;
  assign res_tmo   = res_tmo_q;

  always_comb begin
    state_d   = state_q;
    op_a_d    = op_a_q;
    op_b_d    = op_b_q;
    res_q_d   = res_q_q;
    res_ov_d  = res_ov_q;
    res_dvz_d = res_dvz_q;
    res_tmo_d = res_tmo_q;
    tmo_cnt_d = tmo_cnt_q;
    fifo_pop  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          op_a_d   = fifo_a;
          op_b_d   = fifo_b;
          state_d  = ISSUE;
`ifdef DIV_DISPATCH_DVZ_BYPASS_EN
          if (fifo_b == '0) begin
            res_q_d   = '0;
            res_ov_d  = 1'b0;
            res_dvz_d = 1'b1;
            res_tmo_d = 1'b0;
            state_d   = DONE;
          end
`endif
        end
      end
      ISSUE: begin
        tmo_cnt_d = '0;
        state_d   = WAIT;
      end
      WAIT: begin
        // tmo_cnt_q==0 marks the first WAIT cycle, where a lingering div_valid is ignored.
        if (tmo_cnt_q != '0 && div_valid && !div_busy) begin
          res_q_d   = div_q;
          res_ov_d  = div_ov;
          res_dvz_d = div_dvz;
          res_tmo_d = 1'b0;
          state_d   = DONE;
        end else if (tmo_cnt_q == CW'(TIMEOUT - 1)) begin
          res_q_d   = '0;
          res_ov_d  = 1'b0;
          res_dvz_d = 1'b0;
          res_tmo_d = 1'b1;
          state_d   = DONE;
        end else begin
          tmo_cnt_d = tmo_cnt_q + CW'(1);
        end
      end
      DONE: begin
        if (res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      op_a_q    <= '0;
      op_b_q    <= '0;
      res_q_q   <= '0;
      res_ov_q  <= 1'b0;
      res_dvz_q <= 1'b0;
      res_tmo_q <= 1'b0;
      tmo_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      op_a_q    <= op_a_d;
      op_b_q    <= op_b_d;
      res_q_q   <= res_q_d;
      res_ov_q  <= res_ov_d;
      res_dvz_q <= res_dvz_d;
      res_tmo_q <= res_tmo_d;
      tmo_cnt_q <= tmo_cnt_d;
    end
  end

endmodule

// File: tb/tb_div_dispatch.sv
// Directed bench for div_dispatch with a fixed-latency divider model and a result scoreboard.
module tb_div_dispatch;
  import div_pkg::*;

  localparam int unsigned W       = 10;
  localparam int unsigned DEPTH   = 4;
  localparam int unsigned TIMEOUT = 48;
  localparam int unsigned LAT     = 6;

  logic         clk = 1'b0;
  logic         rst;
  logic         req_valid, req_ready, res_ready, res_valid;
  logic [W-1:0] req_a, req_b, div_a, div_b, res_q;
  logic         div_start, res_ov, res_dvz, res_tmo;
  logic         div_busy  = 1'b0;
  logic         div_valid = 1'b0;
  logic         div_dvz   = 1'b0;
  logic         div_ov    = 1'b0;
  logic [W-1:0] div_q     = '0;
  logic         withhold  = 1'b0;

  div_dispatch #(.W(W), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .div_start (div_start),
    .div_a     (div_a),
    .div_b     (div_b),
    .div_busy  (div_busy),
    .div_valid (div_valid),
    .div_ov    (div_ov),
    .div_dvz   (div_dvz),
    .div_q     (div_q),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_q     (res_q),
    .res_ov    (res_ov),
    .res_dvz   (res_dvz),
    .res_tmo   (res_tmo)
  );

  always #5 clk = ~clk;

  // Divider model: result pulse LAT edges after the edge that samples div_start; never reset.
  int unsigned  mcnt = 0;
  logic [W-1:0] ma = '0, mb = '0;
  always @(posedge clk) begin
    div_valid <= 1'b0;
    if (div_start && !div_busy) begin
      div_busy <= 1'b1;
      mcnt     <= LAT - 1;
      ma       <= div_a;
      mb       <= div_b;
    end else if (div_busy) begin
      if (mcnt == 0) begin
        div_busy <= 1'b0;
        if (!withhold) begin
          div_valid <= 1'b1;
          div_q     <= (mb == '0) ? '0 : W'(ma / mb);
          div_dvz   <= (mb == '0);
        end
      end else begin
        mcnt <= mcnt - 1;
      end
    end
  end

  int unsigned cyc = 0;
  int unsigned start_log[$];
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (div_start) start_log.push_back(cyc + 1);
  end

  div_res_t    exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int unsigned last_res_cyc = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic push(input int a, input int b, input bit tmo, output int waited);
    div_res_t e;
    bit rdy;
    bit ok = 0;
    waited = 0;
    req_valid = 1'b1;
    req_a = W'(a);
    req_b = W'(b);
    for (int i = 0; i < 100; i++) begin
      rdy = req_ready;
      @(posedge clk);
      if (rdy) begin
        ok = 1;
        break;
      end
      waited++;
      @(negedge clk);
    end
    check("push_accept", 32'(ok), 1);
    @(negedge clk);
    req_valid = 1'b0;
    e.q   = tmo ? '0 : ((b == 0) ? '0 : W'(a / b));
    e.ov  = 1'b0;
    e.dvz = !tmo && (b == 0);
    e.tmo = tmo;
    if (ok) exp_q.push_back(e);
  endtask

  task automatic wait_result(input string tag);
    div_res_t e;
    bit seen = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (res_valid) begin
        seen = 1;
        break;
      end
    end
    check({tag, "_valid"}, 32'(seen), 1);
    if (seen) begin
      last_res_cyc = cyc;
      check({tag, "_sb_nonempty"}, 32'(exp_q.size() > 0), 1);
      e = exp_q.pop_front();
      check({tag, "_q"},   32'(res_q),   32'(e.q));
      check({tag, "_ov"},  32'(res_ov),  32'(e.ov));
      check({tag, "_dvz"}, 32'(res_dvz), 32'(e.dvz));
      check({tag, "_tmo"}, 32'(res_tmo), 32'(e.tmo));
      if (res_ready) begin
        @(posedge clk);
        @(negedge clk);
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"}, 32'(req_ready), 1);
    check({tag, "_div_start"}, 32'(div_start), 0);
    check({tag, "_div_a"},     32'(div_a),     0);
    check({tag, "_div_b"},     32'(div_b),     0);
    check({tag, "_res_valid"}, 32'(res_valid), 0);
    check({tag, "_res_q"},     32'(res_q),     0);
    check({tag, "_res_flags"}, 32'({res_ov, res_dvz, res_tmo}), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int a6[6];
    int b6[6];
    int rv;
    a6 = '{100, 200, 1000, 1023, 55, 640};
    b6 = '{7, 9, 10, 1, 5, 33};
    rst = 1'b1;
    req_valid = 1'b0;
    req_a = '0;
    req_b = '0;
    res_ready = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    @(negedge clk);

    // Single request 191/24.
    start_log.delete();
    push(191, 24, 0, w);
    wait_result("single");
    check("single_starts", 32'(start_log.size()), 1);
    if (start_log.size() > 0)
      check("single_latency", last_res_cyc - start_log[0], LAT + 1);

    // Back-to-back requests in consecutive cycles.
    start_log.delete();
    push(104, 16, 0, w);
    push(241, 16, 0, w);
    push(288, 8, 0, w);
    wait_result("b2b0");
    wait_result("b2b1");
    wait_result("b2b2");
    check("b2b_starts", 32'(start_log.size()), 3);
    for (int i = 1; i < start_log.size(); i++)
      check("b2b_spacing", 32'(start_log[i] - start_log[i-1] >= LAT), 1);

    // Divide by zero.
    start_log.delete();
    push(848, 0, 0, w);
    wait_result("dvz");
`ifdef DIV_DISPATCH_DVZ_BYPASS_EN
    check("dvz_starts", 32'(start_log.size()), 0);
`else
    check("dvz_starts", 32'(start_log.size()), 1);
`endif

    // Divider withholds its result.
    withhold = 1'b1;
    start_log.delete();
    push(500, 5, 1, w);
    wait_result("tmo");
    if (start_log.size() > 0)
      check("tmo_latency", last_res_cyc - start_log[0], TIMEOUT);
    else
      check("tmo_start_seen", 0, 1);
    withhold = 1'b0;
    repeat (LAT) @(negedge clk);

    // Backpressure: one in flight plus DEPTH queued, then the sixth push stalls.
    res_ready = 1'b0;
    for (int i = 0; i < 5; i++) push(a6[i], b6[i], 0, w);
    check("full_req_ready", 32'(req_ready), 0);
    repeat (10) @(negedge clk);
    check("full_req_ready_hold", 32'(req_ready), 0);
    wait_result("bp0");
    res_ready = 1'b1;
    push(a6[5], b6[5], 0, w);
    check("bp_push_stalled", 32'(w > 0), 1);
    for (int i = 1; i < 6; i++) wait_result($sformatf("bp%0d", i));

    // Reset during WAIT with two entries queued.
    start_log.delete();
    push(30, 3, 0, w);
    push(90, 9, 0, w);
    push(77, 7, 0, w);
    for (int i = 0; i < 50 && start_log.size() == 0; i++) @(negedge clk);
    check("rst_start_seen", 32'(start_log.size()), 1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    check_reset_outputs("midrst");
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    start_log.delete();
    rv = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (res_valid) rv++;
    end
    check("stale_res_valid", 32'(rv), 0);
    check("stale_starts", 32'(start_log.size()), 0);
    check("post_rst_req_ready", 32'(req_ready), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
